snoop_request_issuer: RTL and testbench

- Requester-side bus stage for the L2 cache simulator; sits directly upstream of the snoop responder.
- Accepts one bus transaction from the L2 controller and drives address/op onto the shared bus, waits for the snoop response to settle, then samples snoopBus.
- Converts the snoop result into the requesting line's MESI next state; retries on HITM up to a limit.

---
 rtl/snoop_request_issuer.sv | 213 +++++++++++++++++++++
 tb/tb_snoop_request_issuer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_request_issuer.sv
// snoop_request_issuer
// Requester-side bus stage for the L2 cache simulator. It accepts one bus
// transaction from the L2 controller and drives the line address and opcode
// onto the shared bus. It waits SNOOP_WAIT cycles for the snoop responder to
// settle, then samples snoopBus and turns the result into the MESI next state
// of the requesting line. A HITM on READ/RWIM backs off for RETRY_DELAY
// cycles and reissues, up to MAX_RETRY times.
//
// Optional build macro: SNOOP_STATS_EN adds 16-bit saturating counters of
// snoop results and retries.
//
// Ports:
//   clk, reset_n           clock; synchronous active-low reset
//   req_valid/req_ready    request handshake (req_ready high only when idle)
//   req_op, req_addr       0=READ 1=WRITE 2=INVALIDATE 3=RWIM; line address
//   sharedBus              address while issuing, otherwise released ('z)
//   sharedOperationBus     {6'b0, op} while issuing, otherwise released ('z)
//   snoopBus               00=NOHIT 01=HIT 10=HITM 11=reserved
//   resp_valid             one-cycle completion pulse
//   resp_snoop             last sampled snoop code
//   resp_state             MESI next state 0=I 1=S 2=E 3=M
//   resp_error             retries exhausted or reserved snoop code
//   stat_nohit/hit/hitm/retry  (SNOOP_STATS_EN only) result/retry counters
//
// Timing: the accept edge puts the FSM in DRIVE for SNOOP_WAIT cycles,
// then SAMPLE for one cycle, then DONE (resp_valid) for one cycle. Each retry
// inserts RETRY_DELAY BACKOFF cycles plus another DRIVE/SAMPLE pass.

module snoop_request_issuer #(
    parameter int lineSize    = 32,
    parameter int SNOOP_WAIT  = 2,
    parameter int RETRY_DELAY = 4,
    parameter int MAX_RETRY   = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [lineSize-1:0] req_addr,
    inout  wire  [lineSize-1:0] sharedBus,
    inout  wire  [7:0]          sharedOperationBus,
    input  logic [1:0]          snoopBus,
    output logic                resp_valid,
    output logic [1:0]          resp_snoop,
    output logic [1:0]          resp_state,
    output logic                resp_error
`ifdef SNOOP_STATS_EN
    ,
    output logic [15:0]         stat_nohit,
    output logic [15:0]         stat_hit,
    output logic [15:0]         stat_hitm,
    output logic [15:0]         stat_retry
`endif
);

    localparam int WW = $clog2(SNOOP_WAIT + 1);
    localparam int DW = $clog2(RETRY_DELAY + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [WW-1:0] WAIT_LAST = WW'(SNOOP_WAIT - 1);
    localparam logic [DW-1:0] DLY_LAST  = DW'(RETRY_DELAY - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_RWIM  = 2'd3;
    localparam logic [1:0] SN_NOHIT = 2'b00;
    localparam logic [1:0] SN_HITM  = 2'b10;
    localparam logic [1:0] SN_RSVD  = 2'b11;
    localparam logic [1:0] MESI_I   = 2'd0;
    localparam logic [1:0] MESI_S   = 2'd1;
    localparam logic [1:0] MESI_E   = 2'd2;
    localparam logic [1:0] MESI_M   = 2'd3;

    typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, BACKOFF, DONE} state_t;

    state_t              state, state_nx;
    logic [lineSize-1:0] addr_q;
    logic [1:0]          op_q;
    logic [WW-1:0]       wait_q;
    logic [DW-1:0]       dly_q;
    logic [RW-1:0]       retry_q;
    logic                bus_drive;
    logic                hitm_retry;
    logic                can_retry;
    logic                sample_err;

    // Next state for a non-error completion. A READ that only succeeded after
    // a HITM ends Shared: the previous owner wrote back and keeps a copy.
    function automatic logic [1:0] mesi_next(input logic [1:0] op,
                                             input logic [1:0] snoop,
                                             input logic       after_hitm);
        if (op == OP_READ) begin
            if (snoop == SN_NOHIT && !after_hitm)
                return MESI_E;
            return MESI_S;
        end
        return MESI_M;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        bus_drive  = 1'b0;
        // Only READ and RWIM need the dirty line from the owner; other ops
        // complete on HITM.
        hitm_retry = (snoopBus == SN_HITM) && (op_q == OP_READ || op_q == OP_RWIM);
        can_retry  = (retry_q < RETRY_MAX);
        sample_err = (snoopBus == SN_RSVD) || (hitm_retry && !can_retry);
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nx = DRIVE;
            end
            DRIVE: begin
                bus_drive = 1'b1;
                if (wait_q == WAIT_LAST)
                    state_nx = SAMPLE;
            end
            SAMPLE: begin
                bus_drive = 1'b1;
                if (hitm_retry && can_retry)
                    state_nx = BACKOFF;
                else
                    state_nx = DONE;
            end
            BACKOFF: begin
                if (dly_q == DLY_LAST)
                    state_nx = DRIVE;
            end
            DONE: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request latch: plain data, captured only on accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            addr_q <= req_addr;
            op_q   <= req_op;
        end
    end

    // Phase counters restart whenever their phase is left, so they never
    // run past their terminal value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_q     <= '0;
            dly_q      <= '0;
            retry_q    <= '0;
            resp_snoop <= SN_NOHIT;
            resp_state <= MESI_I;
            resp_error <= 1'b0;
        end else begin
            wait_q <= (state == DRIVE && state_nx == DRIVE) ? wait_q + 1'b1 : '0;
            dly_q  <= (state == BACKOFF && state_nx == BACKOFF) ? dly_q + 1'b1 : '0;
            if (state == IDLE && req_valid)
                retry_q <= '0;
            else if (state == SAMPLE && state_nx == BACKOFF)
                retry_q <= retry_q + 1'b1;
            if (state == SAMPLE && state_nx == DONE) begin
                resp_snoop <= snoopBus;
                resp_error <= sample_err;
                resp_state <= sample_err ? MESI_I
                                         : mesi_next(op_q, snoopBus, retry_q != '0);
            end
        end
    end

    assign sharedBus          = bus_drive ? addr_q : {lineSize{1'bz}};
    assign sharedOperationBus = bus_drive ? {6'b0, op_q} : 8'hzz;

`ifdef SNOOP_STATS_EN
    localparam logic [1:0] SN_HIT = 2'b01;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_nohit <= '0;
            stat_hit   <= '0;
            stat_hitm  <= '0;
            stat_retry <= '0;
        end else begin
            if (state == SAMPLE) begin
                case (snoopBus)
                    SN_NOHIT: stat_nohit <= sat_inc16(stat_nohit);
                    SN_HIT:   stat_hit   <= sat_inc16(stat_hit);
                    SN_HITM:  stat_hitm  <= sat_inc16(stat_hitm);
                    default:  ;
                endcase
            end
            if (state == SAMPLE && state_nx == BACKOFF)
                stat_retry <= sat_inc16(stat_retry);
        end
    end
`endif

endmodule

// File: tb/tb_snoop_request_issuer.sv
// tb_snoop_request_issuer
// Directed and randomized transactions against snoop_request_issuer. For each
// request a reference model derives the retry count, final snoop code, MESI
// state and error flag from a script of snoop responses. The bench then
// checks the timing of bus drive, resp_valid and req_ready cycle by cycle.
// Cycle k = 0 is the cycle right after the accept edge. resp_valid is
// expected at k = SNOOP_WAIT+1 (+ RETRY_DELAY+SNOOP_WAIT+1 per retry). That
// is SNOOP_WAIT+2 cycles when the accept cycle itself is counted.
// Define SNOOP_STATS_EN to also check the statistics counters.

module tb_snoop_request_issuer;
    localparam int LINE = 32;
    localparam int SW   = 2;
    localparam int RD   = 4;
    localparam int MR   = 3;
    localparam int P    = RD + SW + 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [1:0]      req_op = 2'd0;
    logic [LINE-1:0] req_addr = '0;
    wire  [LINE-1:0] sharedBus;
    wire  [7:0]      sharedOperationBus;
    logic [1:0]      snoopBus = 2'b00;
    logic            resp_valid;
    logic [1:0]      resp_snoop;
    logic [1:0]      resp_state;
    logic            resp_error;
`ifdef SNOOP_STATS_EN
    logic [15:0]     stat_nohit, stat_hit, stat_hitm, stat_retry;
    int              exp_nohit = 0, exp_hit = 0, exp_hitm = 0, exp_retry = 0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    snoop_request_issuer #(
        .lineSize(LINE), .SNOOP_WAIT(SW), .RETRY_DELAY(RD), .MAX_RETRY(MR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_addr(req_addr),
        .sharedBus(sharedBus),
        .sharedOperationBus(sharedOperationBus),
        .snoopBus(snoopBus),
        .resp_valid(resp_valid),
        .resp_snoop(resp_snoop),
        .resp_state(resp_state),
        .resp_error(resp_error)
`ifdef SNOOP_STATS_EN
        ,
        .stat_nohit(stat_nohit),
        .stat_hit(stat_hit),
        .stat_hitm(stat_hitm),
        .stat_retry(stat_retry)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats();
`ifdef SNOOP_STATS_EN
        check("stat_nohit", 32'(stat_nohit), 32'(exp_nohit));
        check("stat_hit",   32'(stat_hit),   32'(exp_hit));
        check("stat_hitm",  32'(stat_hitm),  32'(exp_hitm));
        check("stat_retry", 32'(stat_retry), 32'(exp_retry));
`endif
    endtask

    // One transaction. s0..s3 are the snoop codes presented on successive
    // samples. hold_busy keeps req_valid high with a different op/addr while
    // the issuer is busy.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] addr,
                           input logic [1:0] s0, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [1:0] s3,
                           input bit hold_busy);
        logic [1:0] scr [4];
        logic [1:0] s, e_snoop, e_state;
        logic       e_err;
        bit         had_hitm, drv;
        int         retries, lat, j, ph;
        scr[0] = s0; scr[1] = s1; scr[2] = s2; scr[3] = s3;
        retries = 0; had_hitm = 0; e_err = 0; e_snoop = 2'd0; e_state = 2'd0;
        for (int i = 0; i < 4; i++) begin
            s = scr[i];
`ifdef SNOOP_STATS_EN
            if (s == 2'd0) exp_nohit++;
            else if (s == 2'd1) exp_hit++;
            else if (s == 2'd2) exp_hitm++;
`endif
            if (s == 2'd3) begin
                e_err = 1; e_state = 2'd0; e_snoop = s;
                break;
            end
            if (s == 2'd2 && (op == 2'd0 || op == 2'd3)) begin
                had_hitm = 1;
                if (retries < MR) begin
                    retries++;
`ifdef SNOOP_STATS_EN
                    exp_retry++;
`endif
                    continue;
                end
                e_err = 1; e_state = 2'd0; e_snoop = s;
                break;
            end
            e_snoop = s;
            if (op == 2'd0)
                e_state = (s == 2'd1 || had_hitm) ? 2'd1 : 2'd2;
            else
                e_state = 2'd3;
            break;
        end
        lat = SW + 1 + retries * P;

        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; snoopBus = scr[0];
        @(posedge clk); #1;
        if (hold_busy) begin
            req_op   = op ^ 2'd1;
            req_addr = addr ^ 32'h0000_0100;
        end else begin
            req_valid = 1'b0;
        end
        for (int k = 0; k <= lat + 1; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            j  = k / P;
            ph = k % P;
            drv = (j <= retries) && (ph <= SW) && (k < lat);
            check("resp_valid", 32'(resp_valid), 32'(k == lat));
            check("req_ready",  32'(req_ready),  32'(k == lat + 1));
            if (drv) begin
                check("bus_addr", sharedBus, addr);
                check("bus_op",   32'(sharedOperationBus), 32'({6'b0, op}));
            end else begin
                if (addr != 32'd0)
                    check("bus_addr_released", 32'(sharedBus !== addr), 32'd1);
                if (op != 2'd0)
                    check("bus_op_released", 32'(sharedOperationBus !== {6'b0, op}), 32'd1);
            end
            if (k >= lat) begin
                check("resp_snoop", 32'(resp_snoop), 32'(e_snoop));
                check("resp_state", 32'(resp_state), 32'(e_state));
                check("resp_error", 32'(resp_error), 32'(e_err));
            end
            if (ph == SW + 1 && j < retries)
                snoopBus = scr[j + 1];
            if (k == lat)
                req_valid = 1'b0;
        end
        check_stats();
    endtask

    function automatic logic [1:0] rnd_snoop();
        if ($urandom_range(0, 9) < 4)  return 2'd2;
        if ($urandom_range(0, 19) == 0) return 2'd3;
        return 2'($urandom_range(0, 1));
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_snoop", 32'(resp_snoop), 32'd0);
        check("rst_resp_state", 32'(resp_state), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check_stats();
        @(negedge clk);
        reset_n = 1'b1;

        // directed cases
        run_txn(2'd0, 32'h0000_0002, 2'd1, 2'd1, 2'd1, 2'd1, 0); // READ HIT -> S
        run_txn(2'd0, 32'h0000_0000, 2'd0, 2'd0, 2'd0, 2'd0, 0); // READ NOHIT -> E
        run_txn(2'd1, 32'h0000_0000, 2'd0, 2'd0, 2'd0, 2'd0, 0); // WRITE -> M
        run_txn(2'd1, 32'h0000_0040, 2'd2, 2'd0, 2'd0, 2'd0, 0); // WRITE HITM -> M, no retry
        run_txn(2'd2, 32'h0000_0010, 2'd1, 2'd0, 2'd0, 2'd0, 1); // INVALIDATE -> M, busy req ignored
        run_txn(2'd3, 32'h0000_0004, 2'd2, 2'd2, 2'd2, 2'd2, 0); // RWIM retries exhausted
        run_txn(2'd3, 32'h0000_0008, 2'd2, 2'd0, 2'd0, 2'd0, 0); // RWIM one retry -> M
        run_txn(2'd0, 32'h0000_0020, 2'd2, 2'd0, 2'd0, 2'd0, 0); // READ HITM then NOHIT -> S
        run_txn(2'd0, 32'h0000_0024, 2'd2, 2'd2, 2'd1, 2'd0, 1); // READ HITM x2 then HIT -> S
        run_txn(2'd1, 32'h0000_0030, 2'd3, 2'd0, 2'd0, 2'd0, 0); // reserved code -> error

        // reset while in BACKOFF
        @(negedge clk);
        check("bo_idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = 2'd3; req_addr = 32'h0000_0004; snoopBus = 2'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (SW + 1) @(posedge clk);
        #1;
        check("bo_bus_released", 32'(sharedBus !== 32'h0000_0004), 32'd1);
        check("bo_resp_valid",   32'(resp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("bo_rst_ready",       32'(req_ready),  32'd1);
        check("bo_rst_resp_valid",  32'(resp_valid), 32'd0);
        check("bo_rst_addr_rel",    32'(sharedBus !== 32'h0000_0004), 32'd1);
        check("bo_rst_op_rel",      32'(sharedOperationBus !== 8'h03), 32'd1);
        check("bo_rst_resp_snoop",  32'(resp_snoop), 32'd0);
        check("bo_rst_resp_state",  32'(resp_state), 32'd0);
        check("bo_rst_resp_error",  32'(resp_error), 32'd0);
`ifdef SNOOP_STATS_EN
        exp_nohit = 0; exp_hit = 0; exp_hitm = 0; exp_retry = 0;
`endif
        check_stats();
        @(negedge clk);
        reset_n = 1'b1;
        snoopBus = 2'd0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            check("post_rst_no_resp", 32'(resp_valid), 32'd0);
            check("post_rst_ready",   32'(req_ready),  32'd1);
        end
        run_txn(2'd0, 32'h0000_0050, 2'd1, 2'd0, 2'd0, 2'd0, 0);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            logic [1:0]  rop;
            logic [31:0] raddr;
            rop   = 2'($urandom_range(0, 3));
            raddr = $urandom | 32'h1;
            run_txn(rop, raddr, rnd_snoop(), rnd_snoop(), rnd_snoop(), rnd_snoop(),
                    bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
